pri_enc_8x3_sync: RTL and testbench
===================================

# pri_enc_8x3_sync

Registered 8-to-3 priority encoder with enable and valid flag. Eight request lines are sampled every clock; the index of the highest-numbered asserted line is presented on a 3-bit code one cycle later. Used wherever a one-hot or multi-hot request vector must be reduced to a binary index, such as interrupt or arbitration front ends.

## Interface
- No parameters; widths are fixed at 8 inputs and 3 output bits. The constants live in the package.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- E  input  1  encoder enable, active-high.
- D  input  8  request vector; D[7] has the highest priority and D[0] the lowest.
- Y  output  3  binary index of the highest-priority asserted request (registered).
- V  output  1  valid flag: at least one request was asserted while enabled (registered).
- M  output  1  multi-hit flag; present only when PRI_ENC_MULTI_EN is defined (registered).

## Operation
- Combinational priority function:
  - Y_next = the largest i such that D[i]=1.
  - Y_next = 0 when D = 0.
- V_next = E & (|D).
- When E=1:
  - Y register loads Y_next.
  - V register loads V_next.
- When E=0:
  - Y register loads 3'b000.
  - V register loads 0.
  - D is ignored entirely.
- D = 8'h00 with E=1 gives Y=000 and V=0. V is what distinguishes "no request" from "request on line 0" (Y=000, V=1).
- Multi-hot inputs: the lower-priority bits are ignored. Example: D=8'b0010_0110 → Y=101.
- X/Z on D is not handled. Inputs must be driven to known levels.

## Timing
- Single clock domain; all outputs are driven directly from flops.
- Latency is exactly 1 cycle: D and E sampled at edge n appear on Y, V (and M) after edge n.
- There is no handshake. The block accepts a new vector every cycle at full throughput.
- Reset is synchronous:
  - With rst=1 at a rising edge, Y=000, V=0 and M=0 after that edge.
  - rst has priority over E and D.
  - Asserting rst mid-stream discards the vector sampled on that edge.
  - The first post-reset result appears one cycle after rst is deasserted.
- Before the first reset edge, outputs are undefined.

## Configuration
- Macro: PRI_ENC_MULTI_EN.
- Defined:
  - Output port M exists.
  - M_next = E & (popcount(D) ≥ 2).
  - M is registered alongside Y and V, with the same enable and reset behaviour.
- Undefined:
  - Port M and its logic are absent.
  - Y and V behaviour is identical in both builds.

## Structure
- Package pri_enc_pkg holds:
  - PRI_ENC_IN_W = 8 and PRI_ENC_OUT_W = 3.
  - A typedef for the 3-bit index.
  - The reset value constant for the index (3'b000).
- Sub-module pri_enc_core:
  - Purely combinational.
  - Maps D to index, any-hit flag and, under the macro, multi-hit flag.
- The top level pri_enc_8x3_sync holds only the output register stage, the enable gating and the reset.

## Test plan
- Reset: drive rst=1, E=1, D=8'hFF for 2 cycles → Y=000, V=0, M=0. Release rst → after the next edge Y=111, V=1, M=1.
- One-hot walk: E=1, D=1<<i for i=0..7, one vector per cycle → one cycle later Y=i and V=1 for each i; M=0 throughout.
- Priority: E=1, D=8'b0010_0110 → Y=101, V=1, M=1. Then D=8'b0000_0001 → Y=000, V=1, M=0.
- Empty vs. index 0: E=1, D=8'h00 → Y=000, V=0. Next cycle D=8'h01 → Y=000, V=1.
- Enable: E=0, D=8'h80 → Y=000, V=0, M=0. Raise E=1 with D unchanged → next cycle Y=111, V=1.
- Latency and back-to-back: apply D=8'h04, 8'h40, 8'h10 on consecutive edges with E=1 → Y sequence 010, 110, 100, each one cycle after its input. Assert rst on the middle edge → 000 in place of 110, and V=0 for that cycle.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Package for the registered 8-to-3 priority encoder.
// Holds the fixed vector widths, the index type and the index reset value.
// Build option: PRI_ENC_MULTI_EN adds the multi-hit flag M to the encoder.
package pri_enc_pkg;

  localparam int PRI_ENC_IN_W  = 8;
  localparam int PRI_ENC_OUT_W = 3;

  typedef logic [PRI_ENC_OUT_W-1:0] pri_idx_t;

  localparam pri_idx_t PRI_IDX_RST = 3'b000;

endpackage

// File: rtl/pri_enc_8x3_sync_if.sv
// Bus interface for pri_enc_8x3_sync.
//   E : encoder enable (master -> slave)
//   D : 8-bit request vector, D[7] highest priority (master -> slave)
//   Y : registered index of highest asserted request (slave -> master)
//   V : registered valid flag (slave -> master)
//   M : registered multi-hit flag, only with PRI_ENC_MULTI_EN (slave -> master)
interface pri_enc_8x3_sync_if;
  import pri_enc_pkg::*;

  logic                    E;
  logic [PRI_ENC_IN_W-1:0] D;
  pri_idx_t                Y;
  logic                    V;
`ifdef PRI_ENC_MULTI_EN
  logic                    M;
`endif

`ifdef PRI_ENC_MULTI_EN
  modport master (output E, output D, input Y, input V, input M);
  modport slave  (input E, input D, output Y, output V, output M);
`else
  modport master (output E, output D, input Y, input V);
  modport slave  (input E, input D, output Y, output V);
`endif

endinterface

// File: rtl/pri_enc_core.sv
// Combinational core of the priority encoder.
//   d    : request vector, bit 7 highest priority
//   idx  : index of the highest set bit (0 when d is empty)
//   hit  : at least one bit of d is set
//   multi: two or more bits of d are set (only with PRI_ENC_MULTI_EN)
module pri_enc_core
  import pri_enc_pkg::*;
(
  input  logic [PRI_ENC_IN_W-1:0] d,
  output pri_idx_t                idx,
  output logic                    hit
`ifdef PRI_ENC_MULTI_EN
  ,
  output logic                    multi
`endif
);

  pri_idx_t idx_s;
  logic     hit_s;

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the
  // highest-numbered request wins.
  always_comb begin
    idx_s = PRI_IDX_RST;
    hit_s = 1'b0;
    for (int i = 0; i < PRI_ENC_IN_W; i++) begin
      if (d[i]) begin
        idx_s = PRI_ENC_OUT_W'(i);
        hit_s = 1'b1;
      end else begin
        idx_s = idx_s;
        hit_s = hit_s;
      end
    end
  end

  assign idx = idx_s;
  assign hit = hit_s;

`ifdef PRI_ENC_MULTI_EN
  logic [3:0] cnt_s;

  // Population count of the request vector for the multi-hit flag.
  always_comb begin
    cnt_s = 4'd0;
    for (int i = 0; i < PRI_ENC_IN_W; i++) begin
      cnt_s = cnt_s + {3'd0, d[i]};
    end
  end

  assign multi = (cnt_s >= 4'd2);
`endif

endmodule

// File: rtl/pri_enc_8x3_sync.sv
// Registered 8-to-3 priority encoder with enable and valid flag.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides enable and data
//   bus : pri_enc_8x3_sync_if.slave (E, D in; Y, V and optional M out)
// Build option: PRI_ENC_MULTI_EN adds the registered multi-hit flag M.
// All outputs come straight from flops; latency is one cycle.
module pri_enc_8x3_sync
  import pri_enc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  pri_enc_8x3_sync_if.slave       bus
);

  pri_idx_t idx_s;
  logic     hit_s;
  pri_idx_t y_r;
  logic     v_r;

`ifdef PRI_ENC_MULTI_EN
  logic     multi_s;
  logic     m_r;
`endif

  pri_enc_core u_core (
    .d     (bus.D),
    .idx   (idx_s),
    .hit   (hit_s)
`ifdef PRI_ENC_MULTI_EN
    ,
    .multi (multi_s)
`endif
  );

  // Output register stage: reset wins, then enable gating; disabled clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r <= PRI_IDX_RST;
      v_r <= 1'b0;
    end else if (bus.E) begin
      y_r <= idx_s;
      v_r <= hit_s;
    end else begin
      y_r <= PRI_IDX_RST;
      v_r <= 1'b0;
    end
  end

`ifdef PRI_ENC_MULTI_EN
  // Multi-hit register with the same reset and enable behaviour as Y and V.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r <= 1'b0;
    end else if (bus.E) begin
      m_r <= multi_s;
    end else begin
      m_r <= 1'b0;
    end
  end

  assign bus.M = m_r;
`endif

  assign bus.Y = y_r;
  assign bus.V = v_r;

endmodule

// File: tb/tb_pri_enc_8x3_sync.sv
// Testbench for pri_enc_8x3_sync: directed scenarios followed by random
// vectors, every result compared against a behavioural reference model.
module tb_pri_enc_8x3_sync;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pri_enc_8x3_sync_if bus ();

  pri_enc_8x3_sync dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results for the vector applied on the most recent edge.
  logic [2:0] exp_y;
  logic       exp_v;
  logic       exp_m;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: search downward from the highest-priority line.
  task automatic model(input logic r, input logic e, input logic [7:0] d);
    int idx;
    idx = -1;
    for (int i = 7; i >= 0 && idx < 0; i--) begin
      if (d[i]) idx = i;
    end
    if (r || !e) begin
      exp_y = 3'd0;
      exp_v = 1'b0;
      exp_m = 1'b0;
    end else begin
      exp_y = (idx < 0) ? 3'd0 : 3'(idx);
      exp_v = (idx >= 0);
      exp_m = ($countones(d) >= 2);
    end
  endtask

  // Apply one vector, clock it in, then compare the registered outputs.
  task automatic step(input string tag, input logic r, input logic e, input logic [7:0] d);
    rst   = r;
    bus.E = e;
    bus.D = d;
    model(r, e, d);
    @(posedge clk);
    #1;
    chk({tag, ".Y"}, {5'd0, bus.Y}, {5'd0, exp_y});
    chk({tag, ".V"}, {7'd0, bus.V}, {7'd0, exp_v});
`ifdef PRI_ENC_MULTI_EN
    chk({tag, ".M"}, {7'd0, bus.M}, {7'd0, exp_m});
`endif
  endtask

  initial begin
    logic [7:0] rd;
    total = 0;
    bad   = 0;

    // Reset holds outputs clear even with everything requesting.
    step("rst0", 1'b1, 1'b1, 8'hFF);
    step("rst1", 1'b1, 1'b1, 8'hFF);
    step("rel",  1'b0, 1'b1, 8'hFF);

    // One-hot walk.
    for (int i = 0; i < 8; i++) begin
      rd = 8'd1 << i;
      step($sformatf("walk%0d", i), 1'b0, 1'b1, rd);
    end

    // Priority among multiple hits, then a single low hit.
    step("pri_multi", 1'b0, 1'b1, 8'b0010_0110);
    step("pri_low",   1'b0, 1'b1, 8'b0000_0001);

    // Empty vector versus request on line 0.
    step("empty", 1'b0, 1'b1, 8'h00);
    step("line0", 1'b0, 1'b1, 8'h01);

    // Enable gating.
    step("dis",   1'b0, 1'b0, 8'h80);
    step("en",    1'b0, 1'b1, 8'h80);

    // Back-to-back with reset on the middle edge.
    step("b2b0",  1'b0, 1'b1, 8'h04);
    step("b2b1",  1'b0, 1'b1, 8'h40);
    step("b2b2",  1'b0, 1'b1, 8'h10);
    step("b2r0",  1'b0, 1'b1, 8'h04);
    step("b2r1",  1'b1, 1'b1, 8'h40);
    step("b2r2",  1'b0, 1'b1, 8'h10);

    // Random vectors with occasional disable and reset.
    for (int n = 0; n < 300; n++) begin
      rd = 8'($urandom);
      if (($urandom % 4) == 0) rd = 8'd1 << ($urandom % 8);
      step("rand", ($urandom % 16) == 0, ($urandom % 5) != 0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
